// File: rtl/ball_ctl.sv
// ball_ctl: pong ball FSM -- serve timing, per-frame motion, wall/paddle bounces and goal pulses.
module ball_ctl #(
    parameter int HOR_PIXELS  = 1024,
    parameter int VER_PIXELS  = 768,
    parameter int BALLSIZE    = 15,
    parameter int PAD_HEIGHT  = 145,
    parameter int PAD_WIDTH   = 10,
    parameter int LEFT_PAD_X  = 20,
    parameter int RIGHT_PAD_X = 994,
    parameter int SPEED       = 4,
    parameter int SERVE_DELAY = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [9:0]  pad_l_y,
    input  logic [9:0]  pad_r_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic        score_l,
    output logic        score_r,
    output logic        in_play
);
    typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} state_t;
    localparam logic [11:0] SP   = 12'(SPEED);
    localparam logic [11:0] BS   = 12'(BALLSIZE);
    localparam logic [11:0] PH   = 12'(PAD_HEIGHT);
    localparam logic [11:0] HP   = 12'(HOR_PIXELS);
    localparam logic [11:0] YMAX = 12'(VER_PIXELS - BALLSIZE);
    localparam logic [11:0] LX   = 12'(LEFT_PAD_X + PAD_WIDTH);
    localparam logic [11:0] RX   = 12'(RIGHT_PAD_X);
    localparam logic [10:0] XC   = 11'((HOR_PIXELS - BALLSIZE) / 2);
    localparam logic [9:0]  YC   = 10'((VER_PIXELS - BALLSIZE) / 2);
    localparam int CW = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] CLAST = CW'(SERVE_DELAY - 1);
    state_t state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sl_q, sl_d, sr_q, sr_d;
    logic [11:0] xe, ye, pl, pr;
    logic ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, top, bot;
    // all geometry is evaluated 12 bits wide so nothing wraps near the edges
    assign xe = {1'b0, x_q};
    assign ye = {2'b0, y_q};
    assign pl = {2'b0, pad_l_y};
    assign pr = {2'b0, pad_r_y};
    assign ov_l = (ye + BS > pl) && (ye < pl + PH);
    assign ov_r = (ye + BS > pr) && (ye < pr + PH);
    assign hit_l = !dir_x_q && (xe <= LX + SP) && (xe >= LX) && ov_l;
    assign hit_r = dir_x_q && (xe + BS + SP >= RX) && (xe + BS <= RX) && ov_r;
    assign miss_l = !dir_x_q && !hit_l && (xe < SP);
    assign miss_r = dir_x_q && !hit_r && (xe + BS + SP > HP);
    assign top = !dir_y_q && (ye < SP);
    assign bot = dir_y_q && (ye + SP > YMAX);
    assign ball_x = x_q;
    assign ball_y = y_q;
    assign score_l = sl_q;
    assign score_r = sr_q;
    assign in_play = (state_q == PLAY);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q <= XC;
            y_q <= YC;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            cnt_q <= '0;
            sl_q <= 1'b0;
            sr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            cnt_q <= cnt_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        cnt_d = cnt_q;
        sl_d = 1'b0;
        sr_d = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = XC;
                y_d = YC;
                if (start) begin
                    state_d = SERVE;
                    cnt_d = '0;
                end
            end
            SERVE: begin
                x_d = XC;
                y_d = YC;
                if (frame_tick) begin
                    state_d = (cnt_q == CLAST) ? PLAY : SERVE;
                    cnt_d = (cnt_q == CLAST) ? '0 : cnt_q + 1'b1;
                end
            end
            PLAY: if (frame_tick) begin
                y_d = top ? 10'd0 : bot ? 10'(YMAX) : dir_y_q ? 10'(ye + SP) : 10'(ye - SP);
                dir_y_d = top ? 1'b1 : bot ? 1'b0 : dir_y_q;
                x_d = hit_l ? 11'(LX) : hit_r ? 11'(RX - BS) : (miss_l || miss_r) ? x_q :
                      dir_x_q ? 11'(xe + SP) : 11'(xe - SP);
                dir_x_d = hit_l ? 1'b1 : hit_r ? 1'b0 : dir_x_q;
                state_d = (miss_l || miss_r) ? SCORED : PLAY;
                sl_d = miss_r;
                sr_d = miss_l;
            end
            default: begin
                // serve toward the side that just conceded
                x_d = XC;
                y_d = YC;
                dir_x_d = sl_q;
                cnt_d = '0;
                state_d = SERVE;
            end
        endcase
    end
endmodule

// File: tb/tb_ball_ctl.sv
// tb_ball_ctl: directed checks of serve timing, bounces, paddle hits, goals and reset for ball_ctl.
module tb_ball_ctl;
    logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, start = 1'b0, start2 = 1'b0;
    logic [9:0] pad_l_y = 10'd0, pad_r_y = 10'd600, pad_l2 = 10'd0, pad_r2 = 10'd0;
    logic [10:0] bx, s_x;
    logic [9:0] by, s_y;
    logic sl, sr, ip, s_sl, s_sr, s_ip;
    int n_chk = 0, n_fail = 0;
    int cnt_l = 0, cnt_r = 0, cnt_l2 = 0, cnt_r2 = 0, both = 0;

    typedef struct {
        logic st;
        logic tk;
        int ex;
        int ey;
        int ep;
    } vec_t;
    vec_t vecs[5];

    ball_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .ball_x(bx), .ball_y(by),
        .score_l(sl), .score_r(sr), .in_play(ip)
    );

    ball_ctl #(
        .HOR_PIXELS(40), .VER_PIXELS(24), .BALLSIZE(4), .PAD_HEIGHT(8), .PAD_WIDTH(2),
        .LEFT_PAD_X(2), .RIGHT_PAD_X(34), .SPEED(2), .SERVE_DELAY(2)
    ) dut_s (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start2),
        .pad_l_y(pad_l2), .pad_r_y(pad_r2), .ball_x(s_x), .ball_y(s_y),
        .score_l(s_sl), .score_r(s_sr), .in_play(s_ip)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cnt_l <= cnt_l + int'(sl);
        cnt_r <= cnt_r + int'(sr);
        cnt_l2 <= cnt_l2 + int'(s_sl);
        cnt_r2 <= cnt_r2 + int'(s_sr);
        if ((sl && sr) || (s_sl && s_sr)) both <= both + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pos(input string nm, input int ax, input int ay, input int ex, input int ey);
        chk({nm, "_x"}, ax, ex);
        chk({nm, "_y"}, ay, ey);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic serve();
        run(59);
        chk("serve_59_in_play", int'(ip), 0);
        run(1);
        chk("serve_60_in_play", int'(ip), 1);
        pos("serve_hold", int'(bx), int'(by), 504, 376);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 504, 376, 0};
        vecs[1] = '{1'b0, 1'b1, 504, 376, 0};
        vecs[2] = '{1'b1, 1'b1, 504, 376, 0};
        vecs[3] = '{1'b1, 1'b1, 504, 376, 0};
        vecs[4] = '{1'b0, 1'b0, 504, 376, 0};
        repeat (2) @(negedge clk);
        pos("reset", int'(bx), int'(by), 504, 376);
        chk("reset_in_play", int'(ip), 0);
        chk("reset_scores", int'({sl, sr}), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = vecs[i].st;
            frame_tick = vecs[i].tk;
            @(negedge clk);
            pos($sformatf("vec%0d", i), int'(bx), int'(by), vecs[i].ex, vecs[i].ey);
            chk($sformatf("vec%0d_in_play", i), int'(ip), vecs[i].ep);
        end
        start = 1'b0;
        frame_tick = 1'b0;
        run(58);
        chk("serve1_59_in_play", int'(ip), 0);
        run(1);
        chk("serve1_60_in_play", int'(ip), 1);
        // rally 1: right paddle hit, bottom and top bounces, left miss
        run(1);  pos("s1_k1", int'(bx), int'(by), 508, 380);
        run(93); pos("s1_k94", int'(bx), int'(by), 880, 752);
        run(1);  pos("s1_bottom", int'(bx), int'(by), 884, 753);
        run(1);  pos("s1_k96", int'(bx), int'(by), 888, 749);
        run(22); pos("s1_k118", int'(bx), int'(by), 976, 661);
        run(1);  pos("s1_right_hit", int'(bx), int'(by), 979, 657);
        run(164); pos("s1_p164", int'(bx), int'(by), 323, 1);
        run(1);  pos("s1_top", int'(bx), int'(by), 319, 0);
        run(1);  pos("s1_p166", int'(bx), int'(by), 315, 4);
        run(71); pos("s1_p237", int'(bx), int'(by), 31, 288);
        run(1);  pos("s1_no_hit", int'(bx), int'(by), 27, 292);
        run(6);  pos("s1_p244", int'(bx), int'(by), 3, 316);
        chk("s1_no_score_yet", cnt_r + cnt_l, 0);
        run(1);
        pos("s1_centred", int'(bx), int'(by), 504, 376);
        chk("s1_in_play", int'(ip), 0);
        chk("s1_score_r", cnt_r, 1);
        chk("s1_score_l", cnt_l, 0);
        // rally 2: served left, paddle misses at x=32
        pad_l_y = 10'd300;
        serve();
        run(1);  pos("s2_m1", int'(bx), int'(by), 500, 380);
        run(93); pos("s2_m94", int'(bx), int'(by), 128, 752);
        run(1);  pos("s2_m95", int'(bx), int'(by), 124, 753);
        run(23); pos("s2_m118", int'(bx), int'(by), 32, 661);
        run(1);  pos("s2_no_hit", int'(bx), int'(by), 28, 657);
        run(7);  pos("s2_m126", int'(bx), int'(by), 0, 629);
        run(1);
        pos("s2_centred", int'(bx), int'(by), 504, 376);
        chk("s2_score_r", cnt_r, 2);
        // rally 3: served left moving up, left paddle hit at x=32
        pad_l_y = 10'd0;
        serve();
        run(1);  pos("s3_m1", int'(bx), int'(by), 500, 372);
        run(92); pos("s3_m93", int'(bx), int'(by), 132, 4);
        run(1);  pos("s3_m94", int'(bx), int'(by), 128, 0);
        run(1);  pos("s3_top", int'(bx), int'(by), 124, 0);
        run(1);  pos("s3_m96", int'(bx), int'(by), 120, 4);
        run(22); pos("s3_m118", int'(bx), int'(by), 32, 92);
        run(1);  pos("s3_left_hit", int'(bx), int'(by), 30, 96);
        run(1);  pos("s3_after_hit", int'(bx), int'(by), 34, 100);
        chk("s3_scores", cnt_l + cnt_r, 2);
        start = 1'b1;
        repeat (4) @(negedge clk);
        pos("play_no_tick", int'(bx), int'(by), 34, 100);
        chk("play_start_ignored", int'(ip), 1);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        pos("reset_mid_play", int'(bx), int'(by), 504, 376);
        chk("reset_mid_play_in_play", int'(ip), 0);
        chk("reset_mid_play_scores", int'({sl, sr}), 0);
        @(negedge clk) rst = 1'b0;
        run(2);
        pos("idle_after_reset", int'(bx), int'(by), 504, 376);
        chk("idle_after_reset_in_play", int'(ip), 0);
        // small-geometry instance: right miss, then top-right corner hit
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        run(1);  chk("sm_serve1_in_play", int'(s_ip), 0);
        run(1);  chk("sm_serve2_in_play", int'(s_ip), 1);
        run(1);  pos("sm_k1", int'(s_x), int'(s_y), 20, 12);
        run(4);  pos("sm_k5", int'(s_x), int'(s_y), 28, 20);
        run(1);  pos("sm_bottom", int'(s_x), int'(s_y), 30, 20);
        run(3);  pos("sm_k9", int'(s_x), int'(s_y), 36, 14);
        run(1);
        pos("sm_centred", int'(s_x), int'(s_y), 18, 10);
        chk("sm_score_l", cnt_l2, 1);
        chk("sm_score_r", cnt_r2, 0);
        run(1);  chk("sm_reserve1_in_play", int'(s_ip), 0);
        run(1);  chk("sm_reserve2_in_play", int'(s_ip), 1);
        run(1);  pos("sm_r1", int'(s_x), int'(s_y), 20, 8);
        run(4);  pos("sm_r5", int'(s_x), int'(s_y), 28, 0);
        run(1);  pos("sm_corner", int'(s_x), int'(s_y), 30, 0);
        run(1);  pos("sm_after_corner", int'(s_x), int'(s_y), 28, 2);
        chk("scores_never_both", both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
